// File: rtl/req_pkg.sv
// Shared widths, request payload and issuer state encoding for the
// request pulse issuer and its FIFO.
package req_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } issuer_state_e;

endpackage

// File: rtl/req_fifo.sv
// Single-clock FIFO of request entries with occupancy count.
// Reset is synchronous and active-low; DEPTH must be a power of two.
module req_fifo
  import req_pkg::*;
#(
  parameter type entry_t = req_t,
  parameter int  DEPTH   = 4,
  localparam int CNT_W   = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  entry_t           din_i,
  input  logic             pop_i,
  output entry_t           dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/req_pulse_issuer.sv
// Buffers master write requests and issues each one to the router as a
// single-cycle valid pulse, separated by at least GAP idle cycles.
module req_pulse_issuer #(
  parameter int  ADDR_W = req_pkg::ADDR_W,
  parameter int  DATA_W = req_pkg::DATA_W,
  parameter int  DEPTH  = 4,
  parameter int  GAP    = 1,
  localparam int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_data,
  input  logic              issue_en,
  output logic              valid,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  count,
  output logic              busy
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  req_pkg::issuer_state_e state_q, state_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   valid_q, valid_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      data_q, data_d;

  entry_t           push_req, head;
  logic             pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign push_req = {s_addr, s_data};

  req_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (s_valid),
    .din_i   (push_req),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    valid_d = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    case (state_q)
      req_pkg::IDLE: begin
        if (!fifo_empty && issue_en) begin
          pop     = 1'b1;
          state_d = req_pkg::ISSUE;
        end
      end
      req_pkg::ISSUE: begin
        if (GAP != 0) begin
          gap_d   = GW'(GAP - 1);
          state_d = req_pkg::GAP;
        end else if (!fifo_empty && issue_en) begin
          pop = 1'b1;
        end else begin
          state_d = req_pkg::IDLE;
        end
      end
      req_pkg::GAP: begin
        if (gap_q == '0) state_d = req_pkg::IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = req_pkg::IDLE;
    endcase
    // Payload is only presented alongside the pulse; zero otherwise.
    if (pop) begin
      valid_d = 1'b1;
      addr_d  = head.addr;
      data_d  = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= req_pkg::IDLE;
      gap_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign s_ready  = !fifo_full;
  assign valid    = valid_q;
  assign addr_out = addr_q;
  assign data_out = data_q;
  assign count    = fifo_count;
  assign busy     = (fifo_count != '0) || (state_q != req_pkg::IDLE);

endmodule

// File: tb/tb_req_pulse_issuer.sv
// Bench for req_pulse_issuer: three gap settings driven side by side and
// compared every cycle against a queue-and-timestamp model of the issuer.
module tb_req_pulse_issuer;

  localparam int NI    = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        sv  [NI];
  logic [7:0]  sa  [NI];
  logic [15:0] sd  [NI];
  logic        ie  [NI];
  logic        sr  [NI];
  logic        vo  [NI];
  logic [7:0]  ao  [NI];
  logic [15:0] dout[NI];
  logic [2:0]  cnt [NI];
  logic        bsy [NI];

  req_pulse_issuer #(.GAP(1)) u_g1 (
    .clk(clk), .resetn(resetn), .s_valid(sv[0]), .s_ready(sr[0]),
    .s_addr(sa[0]), .s_data(sd[0]), .issue_en(ie[0]), .valid(vo[0]),
    .addr_out(ao[0]), .data_out(dout[0]), .count(cnt[0]), .busy(bsy[0]));

  req_pulse_issuer #(.GAP(0)) u_g0 (
    .clk(clk), .resetn(resetn), .s_valid(sv[1]), .s_ready(sr[1]),
    .s_addr(sa[1]), .s_data(sd[1]), .issue_en(ie[1]), .valid(vo[1]),
    .addr_out(ao[1]), .data_out(dout[1]), .count(cnt[1]), .busy(bsy[1]));

  req_pulse_issuer #(.GAP(2)) u_g2 (
    .clk(clk), .resetn(resetn), .s_valid(sv[2]), .s_ready(sr[2]),
    .s_addr(sa[2]), .s_data(sd[2]), .issue_en(ie[2]), .valid(vo[2]),
    .addr_out(ao[2]), .data_out(dout[2]), .count(cnt[2]), .busy(bsy[2]));

  int gap_of [NI] = '{1, 0, 2};

  // Model: entries held head-first in an array, plus the edge of the last pop.
  int          t;
  int          m_cnt  [NI];
  logic [23:0] m_buf  [NI][DEPTH];
  int          m_last [NI];
  logic        m_v    [NI];
  logic [23:0] m_out  [NI];
  logic        accepted [NI];

  int n_checks = 0;
  int n_fail   = 0;

  // Directed request list and stimulus knobs.
  logic [23:0] dir_req[$];
  int          dptr [NI];
  logic        rand_mode;
  logic        dir_ie;
  int          p_valid, p_ie;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=0x%0h want=0x%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      int   pre;
      int   spacing;
      logic can;
      accepted[i] = 1'b0;
      if (!resetn) begin
        m_cnt[i]  = 0;
        m_last[i] = -1000;
        m_v[i]    = 1'b0;
        m_out[i]  = '0;
      end else begin
        pre     = m_cnt[i];
        spacing = (gap_of[i] == 0) ? 1 : gap_of[i] + 2;
        accepted[i] = sv[i] && (pre < DEPTH);
        can = (pre > 0) && ie[i] && (t >= m_last[i] + spacing);
        m_v[i]   = 1'b0;
        m_out[i] = '0;
        if (can) begin
          m_v[i]   = 1'b1;
          m_out[i] = m_buf[i][0];
          for (int k = 0; k < DEPTH-1; k++) m_buf[i][k] = m_buf[i][k+1];
          m_cnt[i]  = m_cnt[i] - 1;
          m_last[i] = t;
        end
        if (accepted[i]) begin
          m_buf[i][m_cnt[i]] = {sa[i], sd[i]};
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("valid[%0d]", i),   vo[i],   m_v[i]);
      check($sformatf("addr[%0d]", i),    ao[i],   m_out[i][23:16]);
      check($sformatf("data[%0d]", i),    dout[i], m_out[i][15:0]);
      check($sformatf("count[%0d]", i),   cnt[i],  m_cnt[i]);
      check($sformatf("s_ready[%0d]", i), sr[i],   m_cnt[i] < DEPTH);
      check($sformatf("busy[%0d]", i),    bsy[i],
            (m_cnt[i] != 0) || (m_last[i] + gap_of[i] >= t));
    end
  endtask

  task automatic drive_next();
    for (int i = 0; i < NI; i++) begin
      if (rand_mode) begin
        if (!sv[i] || accepted[i]) begin
          sv[i] = ($urandom_range(99) < p_valid);
          sa[i] = 8'($urandom);
          sd[i] = 16'($urandom);
        end
        ie[i] = ($urandom_range(99) < p_ie);
      end else begin
        if (!sv[i] || accepted[i]) begin
          if (dptr[i] < dir_req.size()) begin
            sv[i] = 1'b1;
            {sa[i], sd[i]} = dir_req[dptr[i]];
            dptr[i]++;
          end else begin
            sv[i] = 1'b0;
          end
        end
        ie[i] = dir_ie;
      end
    end
  endtask

  task automatic cycle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      t++;
      model_edge();
      @(negedge clk);
      check_all();
      drive_next();
    end
  endtask

  task automatic load_dir(input logic [23:0] r0, input logic [23:0] r1,
                          input logic [23:0] r2, input int n);
    dir_req.delete();
    if (n > 0) dir_req.push_back(r0);
    if (n > 1) dir_req.push_back(r1);
    if (n > 2) dir_req.push_back(r2);
    for (int i = 0; i < NI; i++) dptr[i] = 0;
  endtask

  initial begin
    t = 0;
    resetn = 1'b0;
    rand_mode = 1'b0;
    dir_ie = 1'b0;
    p_valid = 50;
    p_ie = 80;
    for (int i = 0; i < NI; i++) begin
      sv[i] = 1'b0; sa[i] = '0; sd[i] = '0; ie[i] = 1'b0;
      m_cnt[i] = 0; m_last[i] = -1000; m_v[i] = 1'b0; m_out[i] = '0;
      accepted[i] = 1'b0; dptr[i] = 0;
    end

    cycle(2);
    resetn = 1'b1;

    // Single request: latency and zeroed payload around the pulse.
    load_dir(24'h12BEEF, 24'h0, 24'h0, 1);
    dir_ie = 1'b1;
    drive_next();
    cycle(8);

    // Fill to full while blocked, fifth request held by the master.
    dir_req.delete();
    dir_req.push_back(24'h100001);
    dir_req.push_back(24'h200002);
    dir_req.push_back(24'h300003);
    dir_req.push_back(24'h400004);
    dir_req.push_back(24'h500005);
    for (int i = 0; i < NI; i++) dptr[i] = 0;
    dir_ie = 1'b0;
    drive_next();
    cycle(8);
    dir_ie = 1'b1;
    drive_next();
    cycle(26);

    // issue_en gating: hold, release one cycle, drop during the pulse.
    load_dir(24'hA1_1111, 24'hA2_2222, 24'h0, 2);
    dir_ie = 1'b0;
    drive_next();
    cycle(5);
    dir_ie = 1'b1;
    drive_next();
    cycle(1);
    dir_ie = 1'b0;
    drive_next();
    cycle(6);
    dir_ie = 1'b1;
    drive_next();
    cycle(10);

    // Back-to-back candidates including addresses 0x3F / 0x40 / 0xFF.
    load_dir(24'h3F_0001, 24'h40_0002, 24'hFF_0003, 3);
    dir_ie = 1'b0;
    drive_next();
    cycle(5);
    dir_ie = 1'b1;
    drive_next();
    cycle(12);

    // Reset during a pulse with entries still queued.
    load_dir(24'h01_0101, 24'h02_0202, 24'h03_0303, 3);
    dir_ie = 1'b0;
    drive_next();
    cycle(5);
    dir_ie = 1'b1;
    drive_next();
    cycle(1);
    resetn = 1'b0;
    cycle(1);
    resetn = 1'b1;
    cycle(10);

    // Randomized traffic with changing load and occasional resets.
    rand_mode = 1'b1;
    for (int blk = 0; blk < 20; blk++) begin
      case ($urandom_range(3))
        0: p_valid = 20;
        1: p_valid = 60;
        default: p_valid = 100;
      endcase
      case ($urandom_range(3))
        0: p_ie = 10;
        1: p_ie = 50;
        2: p_ie = 90;
        default: p_ie = 100;
      endcase
      for (int c = 0; c < 150; c++) begin
        resetn = ($urandom_range(399) != 0);
        cycle(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
